dm_resp: RTL and testbench

- Multi-cycle data-memory responder: the memory-side end of the core's load/store interface.
- Accepts one read or write request from the processor datapath (DMWr-style write strobe, byte address, write data).
- Inserts a fixed number of wait states, then acknowledges for exactly one cycle, returning read data.
- Sits beside the instruction memory under the core top; the core's multi-cycle controller stalls on `busy`/`ack`.

---
 rtl/dm_pkg.sv | 21 ++
 rtl/dm_ram.sv | 52 +++++
 rtl/dm_resp.sv | 137 +++++++++++++
 tb/tb_dm_resp.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder (dm_resp) and its word RAM.
package dm_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned NUM_BYTES = 4;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_e;

    // Request payload captured at acceptance; the word index is held separately.
    typedef struct packed {
        logic                 we;
        logic [NUM_BYTES-1:0] be;
        logic [WORD_W-1:0]    wdata;
    } dm_req_t;

endpackage

// File: rtl/dm_ram.sv
// Word array with a synchronous byte-enabled write port and a registered read port.
// The read register holds its value until the next enabled read.
module dm_ram
    import dm_pkg::*;
#(
    parameter int unsigned IDX_W = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 we,
    input  logic [NUM_BYTES-1:0] be,
    input  logic [IDX_W-1:0]     widx,
    input  logic [WORD_W-1:0]    wdata,
    output logic [WORD_W-1:0]    rdata
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_d;
    logic [WORD_W-1:0] rdata_q;

    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem_q[widx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int unsigned b = 0; b < NUM_BYTES; b++) begin
                if (be[b]) begin
                    mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dm_resp.sv
// Multi-cycle data-memory responder: accept one request, wait WAIT_CYC cycles, ack for one cycle.
// Optional macro DM_ALIGN_CHK_EN: misaligned requests ack with err=1 and leave memory/rdata untouched.
module dm_resp
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [NUM_BYTES-1:0] be,
    input  logic [WORD_W-1:0]    wdata,
    output logic [WORD_W-1:0]    rdata,
    output logic                 ack,
    output logic                 err,
    output logic                 busy
);

    localparam int unsigned IDX_W = ADDR_W - 2;

    dm_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    dm_req_t           cap_q, cap_d;
    logic [IDX_W-1:0]  widx_q, widx_d;
    logic              mis_q, mis_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    dm_req_t           cur_c;
    logic [IDX_W-1:0]  cur_widx_c;
    logic              cur_mis_c;
    logic              ram_en_c;

`ifdef DM_ALIGN_CHK_EN
    logic addr_mis_c;
    assign addr_mis_c = (addr[1:0] != 2'b00);
`else
    logic addr_mis_c;
    logic unused_addr_lsb;
    assign addr_mis_c      = 1'b0;
    assign unused_addr_lsb = ^addr[1:0];
`endif

    // Next state, capture, and the RAM access that coincides with entering RESP.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cap_d      = cap_q;
        widx_d     = widx_q;
        mis_d      = mis_q;
        cur_c      = cap_q;
        cur_widx_c = widx_q;
        cur_mis_c  = mis_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    cap_d      = '{we: we, be: be, wdata: wdata};
                    widx_d     = addr[ADDR_W-1:2];
                    mis_d      = addr_mis_c;
                    cur_c      = cap_d;
                    cur_widx_c = widx_d;
                    cur_mis_c  = mis_d;
                    if (WAIT_CYC == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYC - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A reset at the RESP edge must not commit the write.
        ram_en_c = rst && (state_d == ST_RESP) && !cur_mis_c;
        ack_d    = (state_d == ST_RESP);
        busy_d   = (state_d != ST_IDLE);
        err_d    = ack_d && cur_mis_c;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
            widx_q  <= '0;
            mis_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            widx_q  <= widx_d;
            mis_q   <= mis_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    dm_ram #(
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .en    (ram_en_c),
        .we    (cur_c.we),
        .be    (cur_c.be),
        .widx  (cur_widx_c),
        .wdata (cur_c.wdata),
        .rdata (rdata)
    );

    assign ack  = ack_q;
    assign err  = err_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_dm_resp.sv
// Bench for dm_resp: two instances (WAIT_CYC=2 and WAIT_CYC=0) share stimulus and are checked
// every cycle against a timestamp-based transaction model, plus hand-computed literal expectations.
module tb_dm_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we  = 1'b0;
    logic [11:0] addr  = '0;
    logic [3:0]  be    = '0;
    logic [31:0] wdata = '0;

    logic [31:0] rdata0, rdata1;
    logic        ack0, ack1, err0, err1, busy0, busy1;

    always #5 clk = ~clk;

    dm_resp #(.ADDR_W(12), .WAIT_CYC(2)) u_dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be), .wdata(wdata),
        .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0)
    );

    dm_resp #(.ADDR_W(12), .WAIT_CYC(0)) u_dut_w0 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be), .wdata(wdata),
        .rdata(rdata1), .ack(ack1), .err(err1), .busy(busy1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: each accepted request is described by its acceptance and RESP edges.
    int          edge_n = 0;
    int          acc_e  [2];
    int          done_e [2];
    int          free_e [2];
    bit          pend   [2];
    logic        m_we   [2];
    logic [3:0]  m_be   [2];
    logic [31:0] m_wd   [2];
    int          m_idx  [2];
    bit          m_mis  [2];
    logic [31:0] mmem   [2][1024];
    logic [31:0] m_rd   [2];
    bit          e_ack  [2];
    bit          e_busy [2];
    bit          e_err  [2];

    function automatic int wc(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            acc_e[k] = -10; done_e[k] = -10; free_e[k] = 0; pend[k] = 0;
            m_rd[k] = '0; m_mis[k] = 0;
            for (int i = 0; i < 1024; i++) mmem[k][i] = '0;
        end
        forever begin
            @(posedge clk);
            edge_n++;
            for (int k = 0; k < 2; k++) begin
                if (!rst) begin
                    pend[k] = 0; acc_e[k] = -10; done_e[k] = -10;
                    free_e[k] = edge_n + 1; m_rd[k] = '0;
                end else begin
                    if (!pend[k] && edge_n >= free_e[k] && req) begin
                        acc_e[k]  = edge_n;
                        done_e[k] = edge_n + wc(k);
                        free_e[k] = done_e[k] + 2;
                        m_we[k] = we; m_be[k] = be; m_wd[k] = wdata;
                        m_idx[k] = int'(addr[11:2]);
`ifdef DM_ALIGN_CHK_EN
                        m_mis[k] = (addr[1:0] != 2'b00);
`else
                        m_mis[k] = 0;
`endif
                        pend[k] = 1;
                    end
                    if (pend[k] && edge_n == done_e[k]) begin
                        pend[k] = 0;
                        if (!m_mis[k]) begin
                            if (m_we[k]) begin
                                for (int b = 0; b < 4; b++) begin
                                    if (m_be[k][b]) mmem[k][m_idx[k]][8*b +: 8] = m_wd[k][8*b +: 8];
                                end
                            end else begin
                                m_rd[k] = mmem[k][m_idx[k]];
                            end
                        end
                    end
                end
                e_ack[k]  = (edge_n == done_e[k]);
                e_busy[k] = (edge_n >= acc_e[k]) && (edge_n <= done_e[k]);
                e_err[k]  = e_ack[k] && m_mis[k];
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    bit chk_en = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("ack_w2",   32'(ack0),  32'(e_ack[0]));
                check("busy_w2",  32'(busy0), 32'(e_busy[0]));
                check("err_w2",   32'(err0),  32'(e_err[0]));
                check("rdata_w2", rdata0,     m_rd[0]);
                check("ack_w0",   32'(ack1),  32'(e_ack[1]));
                check("busy_w0",  32'(busy1), 32'(e_busy[1]));
                check("err_w0",   32'(err1),  32'(e_err[1]));
                check("rdata_w0", rdata1,     m_rd[1]);
            end
        end
    end

    int          lat0, lat1;
    logic [31:0] rd0, rd1;
    logic        er0;

    // One-cycle request; records each instance's ack latency (cycles after acceptance) and data.
    task automatic do_req(input logic w, input logic [11:0] a, input logic [3:0] b, input logic [31:0] d);
        bit fin;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        lat0 = -1; lat1 = -1; fin = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            if (ack0 && lat0 < 0) begin lat0 = c; rd0 = rdata0; er0 = err0; end
            if (ack1 && lat1 < 0) begin lat1 = c; rd1 = rdata1; end
            if (lat0 > 0 && lat1 > 0 && !busy0 && !busy1) begin fin = 1; break; end
        end
        check("req_completes", 32'(fin), 32'd1);
    endtask

    int q0[$];
    int q1[$];
    bit saw_ack0;

    initial begin
        #400000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with req asserted.
        rst = 1'b0; req = 1'b1; we = 1'b1; addr = 12'h010; be = 4'hF; wdata = 32'h0BAD0BAD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1;
        check("rst_ack",   32'(ack0),  32'd0);
        check("rst_busy",  32'(busy0), 32'd0);
        check("rst_err",   32'(err0),  32'd0);
        check("rst_rdata", rdata0,     32'h0);
        check("rst_busy_w0", 32'(busy1), 32'd0);
        req = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rst_no_accept", 32'(busy0), 32'd0);

        // Write then read.
        do_req(1'b1, 12'h010, 4'hF, 32'hDEADBEEF);
        check("wr_lat_w2", 32'(lat0), 32'd3);
        check("wr_lat_w0", 32'(lat1), 32'd1);
        check("wr_err",    32'(er0),  32'd0);
        do_req(1'b0, 12'h010, 4'h0, 32'h0);
        check("rd_data_w2", rd0, 32'hDEADBEEF);
        check("rd_data_w0", rd1, 32'hDEADBEEF);

        // Byte enables and be=0 no-op.
        do_req(1'b1, 12'h030, 4'hF, 32'h11223344);
        do_req(1'b1, 12'h030, 4'b0101, 32'hAABBCCDD);
        do_req(1'b0, 12'h030, 4'h0, 32'h0);
        check("be_merge", rd0, 32'h11BB33DD);
        do_req(1'b1, 12'h030, 4'h0, 32'hFFFFFFFF);
        check("be0_acked", 32'(lat0), 32'd3);
        check("be0_rdata_held", rd0, 32'h11BB33DD);
        do_req(1'b0, 12'h030, 4'h0, 32'h0);
        check("be0_unchanged", rd0, 32'h11BB33DD);

        // Held request for 10 edges.
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 12'h010; be = 4'h0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 10) req = 1'b0;
            if (ack0) q0.push_back(c);
            if (ack1) q1.push_back(c);
        end
        check("held_cnt_w2", 32'(q0.size()), 32'd3);
        check("held_cnt_w0", 32'(q1.size()), 32'd5);
        if (q0.size() > 0) check("held_first_w2", 32'(q0[0]), 32'd3);
        if (q1.size() > 0) check("held_first_w0", 32'(q1[0]), 32'd1);
        for (int i = 1; i < q0.size(); i++) check("held_gap_w2", 32'(q0[i] - q0[i-1]), 32'd4);
        for (int i = 1; i < q1.size(); i++) check("held_gap_w0", 32'(q1[i] - q1[i-1]), 32'd2);

        // Reset during WAIT abandons the write on the slow instance.
        do_req(1'b1, 12'h020, 4'hF, 32'h13579BDF);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 12'h020; be = 4'hF; wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; rst = 1'b0;
        saw_ack0 = ack0;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (ack0) saw_ack0 = 1;
            @(negedge clk);
        end
        check("abort_no_ack", 32'(saw_ack0), 32'd0);
        do_req(1'b0, 12'h020, 4'h0, 32'h0);
        check("abort_prior_w2", rd0, 32'h13579BDF);
        check("abort_done_w0",  rd1, 32'hCAFEF00D);

        // Misaligned write to word 4.
        do_req(1'b1, 12'h013, 4'hF, 32'h55667788);
`ifdef DM_ALIGN_CHK_EN
        check("mis_err", 32'(er0), 32'd1);
        do_req(1'b0, 12'h010, 4'h0, 32'h0);
        check("mis_mem", rd0, 32'hDEADBEEF);
`else
        check("mis_err", 32'(er0), 32'd0);
        do_req(1'b0, 12'h010, 4'h0, 32'h0);
        check("mis_mem", rd0, 32'h55667788);
`endif

        repeat (2) @(negedge clk);
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
